mms_ptw: RTL
============

# mms_ptw

Sv32 hardware page-table walker for the instruction-side MMU. On an ITLB miss it takes the virtual page number, issues one or two 32-bit PTE reads on a dedicated memory request port, checks the leaf PTE, and returns either a ready-to-install `itlb_entry_t` or a page fault. It sits between the ITLB (requester and consumer) and the memory-side arbiter, and owns that port for the duration of a walk.

## Interface
- `ASID_WD`, default 9: ASID width; matches `itlb_entry_t.asid`.
- `PA_WD`, default 34: physical address width (Sv32).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `satp_ppn` in 22: root page-table PPN; sampled when a request is accepted.
- `flush` in 1: sfence/ASID change; aborts any walk in progress.
- `req_valid` in 1: ITLB miss request.
- `req_ready` out 1: high only in IDLE.
- `req_vpn` in 20: {vpn1, vpn0}.
- `req_asid` in ASID_WD: ASID copied into the entry.
- `req_mode` in 2: privilege mode, 2'b00 = U, 2'b01 = S.
- `mem_req_valid` out 1: PTE read request.
- `mem_req_ready` in 1: arbiter grant.
- `mem_req_addr` out PA_WD: PTE byte address.
- `mem_rsp_valid` in 1: read data returned. Exactly one response per accepted request, in order, at least 1 cycle after the handshake.
- `mem_rsp_data` in 32: PTE (`pte_t` layout).
- `rsp_valid` out 1: one-cycle completion pulse. Not back-pressurable.
- `rsp_entry` out `itlb_entry_t`: translated entry.
- `rsp_fault` out 1: instruction page fault. `rsp_entry` is don't-care when set.

## Operation
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN.
- **IDLE**
  - On `req_valid & req_ready`, latch vpn, asid, mode and `satp_ppn`, then go to L1_REQ.
- **L1_REQ**
  - `mem_req_addr = {satp_ppn, vpn1, 2'b00}`.
  - `mem_req_valid` is held until `mem_req_ready`, then go to L1_WAIT.
- **L1_WAIT**
  - On `mem_rsp_valid`, evaluate the PTE in that cycle.
  - Invalid (V=0, or W=1 & R=0): fault, go to DONE.
  - Leaf (R|X): apply the leaf checks below. Superpage misaligned (ppn0 != 0): fault. Otherwise go to DONE with `pg_entry.ppn0 = vpn0`, so the installed entry is 4 KiB granular.
  - Non-leaf: latch the PTE ppn and go to L0_REQ.
- **L0_REQ**
  - `mem_req_addr = {ppn1, ppn0, vpn0, 2'b00}`, same handshake as L1_REQ, then go to L0_WAIT.
- **L0_WAIT**
  - On response: invalid PTE or non-leaf PTE means fault; otherwise apply the leaf checks. Go to DONE.
- **Leaf checks:** fault if X=0, or A=0 (no hardware A/D update), or (mode U & U=0), or (mode S & U=1).
- **Entry fields:**
  - `tag = latched vpn`.
  - `asid = latched asid`.
  - `mode = latched mode`.
  - `pg_entry` = leaf PTE, with the superpage ppn0 substitution above.
- **DONE**
  - `rsp_valid = ~flush`; `rsp_entry` and `rsp_fault` come from registers.
  - Go to IDLE.
- **Flush** (highest priority):
  - IDLE or DONE: go to IDLE.
  - L1_REQ or L0_REQ: if `mem_req_ready` is high that same cycle the handshake stands and the next state is DRAIN; otherwise go to IDLE (valid dropped only under flush).
  - L1_WAIT or L0_WAIT: if `mem_rsp_valid` is high that cycle go to IDLE, else go to DRAIN.
  - DRAIN: wait for `mem_rsp_valid`, discard the data, go to IDLE. No `rsp_valid` is issued.
- **Reset:**
  - State goes to IDLE.
  - Outputs: `req_ready=1`, `mem_req_valid=0`, `mem_req_addr=0`, `rsp_valid=0`, `rsp_fault=0`, `rsp_entry=0`.
  - Reset mid-walk abandons any outstanding response. The arbiter is reset alongside.

## Timing
- One walk at a time; at most one memory request outstanding.
- Request accepted at cycle 0. With a zero-wait grant and 1-cycle response:
  - Superpage or L1 fault: `rsp_valid` at cycle 3.
  - Two-level walk: `rsp_valid` at cycle 5.
- `req_ready` returns high the cycle after DONE.
- All outputs are registered except `rsp_valid` (state & ~flush) and `req_ready` (state == IDLE).

## Structure
- Add to `mms_pkg`:
  - `ptw_state_t` enum.
  - `PTE_BYTES` = 4.
  - `SATP_PPN_WD` = 22.
  - `mms_sv32_mode_t` (U=2'b00, S=2'b01).
- Reuse `pte_t`, `va_t` and `itlb_entry_t` from `mms_pkg`.
- One sub-module, `mms_pte_check`: combinational validity, leaf, misalignment and permission decode of a `pte_t` given level and mode. `mms_ptw` holds the FSM and registers.

## Test plan
- **Two-level walk, S mode:**
  - Setup: `satp_ppn=0x00080`, vpn=0x12345.
  - Expect L1 read at addr 0x80120; return 0x00024001.
  - Expect L0 read at addr 0x90D14; return 0x048D1449.
  - Required: `rsp_valid` at cycle 5, `rsp_fault=0`, ppn1=0x048, ppn0=0x345, tag=0x12345.
- **Superpage:** L1 returns 0x01000049 -> `rsp_valid` at cycle 3, ppn1=0x010, ppn0=0x345, no fault.
- **Misaligned superpage:** L1 returns 0x01000449 -> `rsp_fault=1`, no L0 request issued.
- **Permission faults:**
  - Mode U with a leaf whose U=0 -> fault.
  - Leaf with A=0 -> fault.
  - L0 PTE that is non-leaf -> fault.
  - V=0 at L1 -> fault at cycle 3.
- **Flush in L1_WAIT:** response arrives 4 cycles later -> DRAIN consumes it, no `rsp_valid`, `req_ready` high the cycle after the response.
- **Back-pressure and flush in REQ:**
  - Hold `mem_req_ready=0` for 5 cycles -> `mem_req_valid` and addr stay stable.
  - Flush with ready=0 -> IDLE next cycle.
  - Flush with ready=1 -> DRAIN.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared MMU types for the instruction-side Sv32 translation path.
// Holds the PTE / VA / ITLB-entry layouts, the page-table-walker state
// encoding and the PTE address helper used by mms_ptw.
package mms_pkg;

  localparam int ITLB_ASID_WD = 9;
  localparam int SV32_PA_WD   = 34;
  localparam int PTE_BYTES    = 4;
  localparam int SATP_PPN_WD  = 22;

  typedef enum logic [1:0] {
    MODE_U = 2'b00,
    MODE_S = 2'b01
  } mms_sv32_mode_t;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic [9:0]  vpn1;
    logic [9:0]  vpn0;
    logic [11:0] offset;
  } va_t;

  typedef struct packed {
    logic [19:0]             tag;
    logic [ITLB_ASID_WD-1:0] asid;
    mms_sv32_mode_t          mode;
    pte_t                    pg_entry;
  } itlb_entry_t;

  typedef enum logic [2:0] {
    PTW_IDLE    = 3'd0,
    PTW_L1_REQ  = 3'd1,
    PTW_L1_WAIT = 3'd2,
    PTW_L0_REQ  = 3'd3,
    PTW_L0_WAIT = 3'd4,
    PTW_DONE    = 3'd5,
    PTW_DRAIN   = 3'd6
  } ptw_state_t;

  // Byte address of entry 'idx' in the page table rooted at 'table_ppn'.
  function automatic logic [SV32_PA_WD-1:0] pte_addr(input logic [SATP_PPN_WD-1:0] table_ppn,
                                                     input logic [9:0] idx);
    return {table_ppn, 12'h000} + SV32_PA_WD'(idx) * SV32_PA_WD'(PTE_BYTES);
  endfunction

endpackage

// File: rtl/mms_pte_check.sv
// Combinational decode of one Sv32 PTE.
// Ports:
//   i_pte          PTE under inspection
//   i_level1       1 when the PTE came from the root (L1) table
//   i_mode         privilege mode of the fetch (U or S)
//   o_invalid      V=0, or the reserved W=1/R=0 combination
//   o_leaf         R or X set
//   o_misaligned   L1 leaf whose ppn0 is non-zero
//   o_perm_fault   leaf not usable for an instruction fetch in i_mode
module mms_pte_check
  import mms_pkg::*;
(
  input  pte_t           i_pte,
  input  logic           i_level1,
  input  mms_sv32_mode_t i_mode,
  output logic           o_invalid,
  output logic           o_leaf,
  output logic           o_misaligned,
  output logic           o_perm_fault
);

  logic w_unused;

  assign o_invalid    = ~i_pte.v | (i_pte.w & ~i_pte.r);
  assign o_leaf       = i_pte.r | i_pte.x;
  assign o_misaligned = i_level1 & o_leaf & (i_pte.ppn0 != 10'd0);

  // A must already be set: there is no hardware A/D update path.
  assign o_perm_fault = ~i_pte.x | ~i_pte.a
                      | ((i_mode == MODE_U) & ~i_pte.u)
                      | ((i_mode == MODE_S) &  i_pte.u);

  assign w_unused = &{1'b0, i_pte.ppn1, i_pte.rsw, i_pte.d, i_pte.g};

endmodule

// File: rtl/mms_ptw.sv
// Sv32 instruction-side page-table walker.
// Takes an ITLB miss, reads one or two PTEs over a dedicated memory port
// and returns either an installable itlb_entry_t or a page fault.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   satp_ppn                  root table PPN, captured with the request
//   flush                     abort any walk in progress
//   req_*                     ITLB miss request (valid/ready handshake)
//   mem_req_*                 PTE read request to the arbiter
//   mem_rsp_*                 PTE read data, one per accepted request, in order
//   rsp_valid/entry/fault     one-cycle completion pulse
//
// state   | meaning
// IDLE    | ready for a miss
// L1_REQ  | root PTE read presented, waiting for grant
// L1_WAIT | root PTE read outstanding
// L0_REQ  | leaf-table PTE read presented, waiting for grant
// L0_WAIT | leaf-table PTE read outstanding
// DONE    | result registered, rsp_valid pulses
// DRAIN   | walk aborted, swallowing the outstanding response
module mms_ptw
  import mms_pkg::*;
#(
  parameter int ASID_WD = 9,
  parameter int PA_WD   = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SATP_PPN_WD-1:0] satp_ppn,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [19:0]            req_vpn,
  input  logic [ASID_WD-1:0]     req_asid,
  input  logic [1:0]             req_mode,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PA_WD-1:0]       mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  output logic                   rsp_valid,
  output itlb_entry_t            rsp_entry,
  output logic                   rsp_fault
);

  ptw_state_t     r_state;
  logic [19:0]    r_vpn;
  logic [ASID_WD-1:0] r_asid;
  mms_sv32_mode_t r_mode;
  logic           r_mem_req_valid;
  logic [PA_WD-1:0] r_mem_req_addr;
  itlb_entry_t    r_rsp_entry;
  logic           r_rsp_fault;

  pte_t        w_pte;
  pte_t        w_leaf_pte;
  itlb_entry_t w_entry;
  logic        w_l1;
  logic        w_invalid;
  logic        w_leaf;
  logic        w_misaligned;
  logic        w_perm_fault;
  logic        w_fault;

  assign w_pte = pte_t'(mem_rsp_data);
  assign w_l1  = (r_state == PTW_L1_WAIT);

  mms_pte_check u_pte_check (
    .i_pte        (w_pte),
    .i_level1     (w_l1),
    .i_mode       (r_mode),
    .o_invalid    (w_invalid),
    .o_leaf       (w_leaf),
    .o_misaligned (w_misaligned),
    .o_perm_fault (w_perm_fault)
  );

  // A non-leaf is only legal at L1; at L0 it is a fault.
  assign w_fault = w_invalid | (w_leaf ? (w_misaligned | w_perm_fault) : ~w_l1);

  // Superpages are installed as 4 KiB pages: ppn0 comes from the VA.
  always_comb begin
    w_leaf_pte = w_pte;
    if (w_l1) w_leaf_pte.ppn0 = r_vpn[9:0];
  end

  assign w_entry = '{tag: r_vpn, asid: ITLB_ASID_WD'(r_asid), mode: r_mode, pg_entry: w_leaf_pte};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= PTW_IDLE;
      r_vpn           <= '0;
      r_asid          <= '0;
      r_mode          <= MODE_U;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_rsp_entry     <= '0;
      r_rsp_fault     <= 1'b0;
    end else begin
      case (r_state)
        PTW_IDLE: begin
          if (!flush && req_valid) begin
            r_vpn           <= req_vpn;
            r_asid          <= req_asid;
            r_mode          <= mms_sv32_mode_t'(req_mode);
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= PA_WD'(pte_addr(satp_ppn, req_vpn[19:10]));
            r_state         <= PTW_L1_REQ;
          end
        end
        PTW_L1_REQ, PTW_L0_REQ: begin
          // A grant in the flush cycle still launches the read, so it must be drained.
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            if (flush)                    r_state <= PTW_DRAIN;
            else if (r_state == PTW_L1_REQ) r_state <= PTW_L1_WAIT;
            else                          r_state <= PTW_L0_WAIT;
          end else if (flush) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= PTW_IDLE;
          end
        end
        PTW_L1_WAIT, PTW_L0_WAIT: begin
          if (flush) begin
            r_state <= mem_rsp_valid ? PTW_IDLE : PTW_DRAIN;
          end else if (mem_rsp_valid) begin
            if (w_fault) begin
              r_rsp_fault <= 1'b1;
              r_state     <= PTW_DONE;
            end else if (w_leaf) begin
              r_rsp_fault <= 1'b0;
              r_rsp_entry <= w_entry;
              r_state     <= PTW_DONE;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= PA_WD'(pte_addr({w_pte.ppn1, w_pte.ppn0}, r_vpn[9:0]));
              r_state         <= PTW_L0_REQ;
            end
          end
        end
        PTW_DONE: r_state <= PTW_IDLE;
        PTW_DRAIN: begin
          if (mem_rsp_valid) r_state <= PTW_IDLE;
        end
        default: r_state <= PTW_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == PTW_IDLE);
  assign rsp_valid     = (r_state == PTW_DONE) & ~flush;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign rsp_entry     = r_rsp_entry;
  assign rsp_fault     = r_rsp_fault;

endmodule
